// File: rtl/cube_root_if.sv
// Handshake bundle for cube_root: operand channel (in_*) and result channel (out_*).
// The producer/consumer side uses the master modport; cube_root uses the slave modport.
interface cube_root_if #(
    parameter int unsigned IN_W   = 32,
    parameter int unsigned ROOT_W = 11
) ();
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_x;
    logic              out_valid;
    logic              out_ready;
    logic [ROOT_W-1:0] out_root;
    logic [IN_W-1:0]   out_rem;

    modport master (
        output in_valid, in_x, out_ready,
        input  in_ready, out_valid, out_root, out_rem
    );

    modport slave (
        input  in_valid, in_x, out_ready,
        output in_ready, out_valid, out_root, out_rem
    );
endinterface

// File: rtl/cube_root.sv
// Bit-serial integer cube root: root = floor(cbrt(x)), rem = x - root^3, one root bit per step.
// Define CUBE_ROOT_MUL2_EN to split each trial cube over two cycles (registered square, then cube).
module cube_root #(
    parameter int unsigned IN_W   = 32,
    parameter int unsigned ROOT_W = 11
) (
    input  logic      clock,
    input  logic      reset_done,
    cube_root_if.slave bus
);
    localparam int unsigned CUBE_W = 3 * ROOT_W;
    localparam int unsigned K_W    = $clog2(ROOT_W);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state;
    logic [IN_W-1:0]   x_reg;
    logic [ROOT_W-1:0] root_acc;
    logic [CUBE_W-1:0] acc_cube;
    logic [K_W-1:0]    k;
    logic              out_valid_r;
    logic [ROOT_W-1:0] out_root_r;
    logic [IN_W-1:0]   out_rem_r;

    logic [ROOT_W-1:0] trial;
    logic [CUBE_W-1:0] cube_t;
    logic              fits;
    logic              step_en;
    logic [IN_W-1:0]   rem_next;

    assign trial = root_acc | (ROOT_W'(1) << k);

`ifdef CUBE_ROOT_MUL2_EN
    localparam int unsigned SQ_W = 2 * ROOT_W;
    logic            phase_b;
    logic [SQ_W-1:0] sq;
    assign cube_t  = CUBE_W'(sq) * CUBE_W'(trial);
    assign step_en = phase_b;
`else
    assign cube_t  = CUBE_W'(trial) * CUBE_W'(trial) * CUBE_W'(trial);
    assign step_en = 1'b1;
`endif

    assign fits = (cube_t <= CUBE_W'(x_reg));

    // acc_cube tracks root_acc^3, so the remainder needs no extra multiplier
    always_comb begin
        rem_next = x_reg - (fits ? cube_t[IN_W-1:0] : acc_cube[IN_W-1:0]);
    end

    always_ff @(posedge clock or posedge reset_done) begin
        if (reset_done) begin
            state       <= IDLE;
            x_reg       <= '0;
            root_acc    <= '0;
            acc_cube    <= '0;
            k           <= '0;
            out_valid_r <= 1'b0;
            out_root_r  <= '0;
            out_rem_r   <= '0;
`ifdef CUBE_ROOT_MUL2_EN
            phase_b     <= 1'b0;
            sq          <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        x_reg    <= bus.in_x;
                        root_acc <= '0;
                        acc_cube <= '0;
                        k        <= K_W'(ROOT_W - 1);
                        state    <= CALC;
`ifdef CUBE_ROOT_MUL2_EN
                        phase_b  <= 1'b0;
`endif
                    end
                end
                CALC: begin
`ifdef CUBE_ROOT_MUL2_EN
                    sq      <= SQ_W'(trial) * SQ_W'(trial);
                    phase_b <= ~phase_b;
`endif
                    if (step_en) begin
                        if (fits) begin
                            root_acc <= trial;
                            acc_cube <= cube_t;
                        end
                        if (k == '0) begin
                            state       <= DONE;
                            out_valid_r <= 1'b1;
                            out_root_r  <= fits ? trial : root_acc;
                            out_rem_r   <= rem_next;
                        end else begin
                            k <= k - K_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.out_root  = out_root_r;
    assign bus.out_rem   = out_rem_r;
endmodule

// File: tb/tb_cube_root.sv
// Self-checking bench for cube_root: directed boundaries, backpressure, reset abort,
// cube->cube_root chain and random operands against an arithmetic reference.
module tb_cube_root;
    localparam int unsigned IN_W   = 32;
    localparam int unsigned ROOT_W = 11;
`ifdef CUBE_ROOT_MUL2_EN
    localparam int unsigned LAT = 2 * ROOT_W;
`else
    localparam int unsigned LAT = ROOT_W;
`endif

    logic clock      = 1'b0;
    logic reset_done = 1'b1;

    cube_root_if #(.IN_W(IN_W), .ROOT_W(ROOT_W)) bus_if ();

    cube_root #(.IN_W(IN_W), .ROOT_W(ROOT_W)) dut (
        .clock      (clock),
        .reset_done (reset_done),
        .bus        (bus_if)
    );

    always #5 clock = ~clock;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Largest r with r^3 <= x, found by plain counting.
    function automatic longint unsigned ref_root(input longint unsigned x);
        longint unsigned r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    task automatic run_op(input logic [31:0] x, input bit ready_early, input int stall,
                          output logic [ROOT_W-1:0] root, output logic [IN_W-1:0] rem);
        longint unsigned er;
        longint unsigned erem;
        int unsigned cyc;
        er   = ref_root(longint'(x));
        erem = longint'(x) - er * er * er;
        cyc  = 0;
        check_value("in_ready_idle", 64'(bus_if.in_ready), 64'd1);
        bus_if.in_valid  = 1'b1;
        bus_if.in_x      = x;
        bus_if.out_ready = ready_early;
        @(posedge clock); #1;
        bus_if.in_valid = 1'b0;
        bus_if.in_x     = $urandom;
        check_value("in_ready_busy", 64'(bus_if.in_ready), 64'd0);
        while (!bus_if.out_valid && cyc < 200) begin
            @(posedge clock); #1;
            cyc++;
        end
        check_value("latency", 64'(cyc), 64'(LAT));
        check_value("root", 64'(bus_if.out_root), 64'(er));
        check_value("rem", 64'(bus_if.out_rem), 64'(erem));
        root = bus_if.out_root;
        rem  = bus_if.out_rem;
        if (!ready_early) begin
            for (int i = 0; i < stall; i++) begin
                bus_if.in_valid = 1'b1;
                bus_if.in_x     = $urandom;
                @(posedge clock); #1;
                check_value("stall_valid", 64'(bus_if.out_valid), 64'd1);
                check_value("stall_root", 64'(bus_if.out_root), 64'(er));
                check_value("stall_rem", 64'(bus_if.out_rem), 64'(erem));
                check_value("stall_in_ready", 64'(bus_if.in_ready), 64'd0);
            end
            bus_if.in_valid  = 1'b0;
            bus_if.out_ready = 1'b1;
        end
        @(posedge clock); #1;
        bus_if.out_ready = 1'b0;
        check_value("post_hs_valid", 64'(bus_if.out_valid), 64'd0);
        check_value("post_hs_in_ready", 64'(bus_if.in_ready), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [ROOT_W-1:0] r;
        logic [IN_W-1:0]   m;
        int unsigned       expect_q[$];
        int unsigned       num;

        bus_if.in_valid  = 1'b0;
        bus_if.in_x      = '0;
        bus_if.out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_value("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
        check_value("rst_out_root", 64'(bus_if.out_root), 64'd0);
        check_value("rst_out_rem", 64'(bus_if.out_rem), 64'd0);
        check_value("rst_in_ready", 64'(bus_if.in_ready), 64'd1);
        reset_done = 1'b0;
        @(posedge clock); #1;

        run_op(32'd27, 1'b1, 0, r, m);
        check_value("c27_root", 64'(r), 64'd3);
        check_value("c27_rem", 64'(m), 64'd0);
        run_op(32'd26, 1'b0, 0, r, m);
        check_value("c26_root", 64'(r), 64'd2);
        check_value("c26_rem", 64'(m), 64'd18);
        run_op(32'd0, 1'b0, 0, r, m);
        check_value("c0_root", 64'(r), 64'd0);
        check_value("c0_rem", 64'(m), 64'd0);
        run_op(32'hFFFF_FFFF, 1'b0, 0, r, m);
        check_value("cmax_root", 64'(r), 64'd1625);
        check_value("cmax_rem", 64'(m), 64'd3951670);
        run_op(32'd4291015625, 1'b0, 20, r, m);
        check_value("c1625_root", 64'(r), 64'd1625);
        check_value("c1625_rem", 64'(m), 64'd0);

        // Abort a calculation with reset part-way through.
        run_op(32'd26, 1'b0, 0, r, m);
        bus_if.in_valid = 1'b1;
        bus_if.in_x     = 32'd1000;
        @(posedge clock); #1;
        bus_if.in_valid = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        reset_done = 1'b1;
        #1;
        check_value("abort_out_valid", 64'(bus_if.out_valid), 64'd0);
        check_value("abort_out_root", 64'(bus_if.out_root), 64'd0);
        check_value("abort_out_rem", 64'(bus_if.out_rem), 64'd0);
        check_value("abort_in_ready", 64'(bus_if.in_ready), 64'd1);
        @(posedge clock); #1;
        reset_done = 1'b0;
        @(posedge clock); #1;
        run_op(32'd1000, 1'b0, 0, r, m);
        check_value("c1000_root", 64'(r), 64'd10);
        check_value("c1000_rem", 64'(m), 64'd0);

        // Cube stage modelled arithmetically; roots must return the original operand.
        for (int unsigned n = 1; n <= 200; n++) begin
            expect_q.push_back(n);
            run_op(32'(n * n * n), 1'b0, 0, r, m);
            num = expect_q.pop_front();
            check_value("chain_root", 64'(r), 64'(num));
            check_value("chain_rem", 64'(m), 64'd0);
        end

        for (int i = 0; i < 40; i++) begin
            run_op($urandom, ($urandom_range(0, 1) == 1), int'($urandom_range(0, 3)), r, m);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
